adpll_ctrl: RTL and testbench

Parametrised, synthesisable ADPLL frequency-control and lock-tracking block. It accepts speed-code requests over a valid/ready handshake and slews the applied DCO code toward the target at a bounded rate per reference cycle. It reports the equivalent output period in picoseconds and manages ADPLL_LOCK, including dropping lock on retune and re-acquiring it afterwards. It sits between the system speed-select logic and the DCO/clock model, and all logic runs in the REF_CLK domain.

---
 rtl/adpll_ctrl.sv | 75 +++++++
 tb/tb_adpll_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/adpll_ctrl.sv
// adpll_ctrl: ADPLL DCO code slew controller with lock tracking and period reporting.
module adpll_ctrl #(
  parameter int SPEED_W     = 10,
  parameter int SLEW        = 16,
  parameter int LOCK_CYCLES = 10,
  parameter int INIT_CODE   = 0,
  parameter int BASE_PS     = 900,
  parameter int STEP_PS     = 10,
  parameter int PER_W       = 16
) (
  input  logic               REF_CLK,
  input  logic               RESET,
  input  logic [SPEED_W-1:0] speed_req,
  input  logic               speed_req_valid,
  output logic               speed_req_ready,
  output logic [SPEED_W-1:0] dco_code,
  output logic [PER_W-1:0]   period_ps,
  output logic               ADPLL_LOCK,
  output logic               busy,
  output logic               lock_lost
);
  localparam int CW = $clog2(LOCK_CYCLES + 1);
  // a slew wider than the code range can never be the limiting term
  localparam int SL = (SLEW > 2**SPEED_W - 1) ? 2**SPEED_W - 1 : SLEW;
  typedef enum logic [1:0] {HOLD, RAMP, LOCKED} state_t;
  state_t             state;
  logic [SPEED_W-1:0] target;
  logic [CW-1:0]      cnt;
  logic [SPEED_W:0]   diff;
  logic [SPEED_W:0]   mag;
  logic [SPEED_W-1:0] step;
  logic [SPEED_W-1:0] next_code;
  logic               accept;
  assign busy            = (state == RAMP);
  assign speed_req_ready = !busy;
  assign period_ps       = PER_W'(BASE_PS) + PER_W'(STEP_PS) * PER_W'(dco_code);
  assign accept          = speed_req_valid && !busy && (speed_req != dco_code);
  always_comb begin
    diff      = {1'b0, target} - {1'b0, dco_code};
    mag       = diff[SPEED_W] ? -diff : diff;
    step      = (mag > (SPEED_W+1)'(SL)) ? SPEED_W'(SL) : mag[SPEED_W-1:0];
    next_code = diff[SPEED_W] ? dco_code - step : dco_code + step;
  end
  always_ff @(posedge REF_CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= HOLD;
      dco_code   <= SPEED_W'(INIT_CODE);
      target     <= SPEED_W'(INIT_CODE);
      cnt        <= '0;
      ADPLL_LOCK <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (accept) begin
        target     <= speed_req;
        state      <= RAMP;
        cnt        <= '0;
        ADPLL_LOCK <= 1'b0;
        lock_lost  <= (state == LOCKED);
      end else if (state == RAMP) begin
        dco_code <= next_code;
        if (next_code == target) begin
          state <= HOLD;
          cnt   <= '0;
        end
      end else if (state == HOLD) begin
        cnt <= cnt + 1'b1;
        if (cnt + 1'b1 == CW'(LOCK_CYCLES)) begin
          state      <= LOCKED;
          ADPLL_LOCK <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_adpll_ctrl.sv
// tb_adpll_ctrl: directed scenarios for adpll_ctrl with hand-computed codes and periods.
module tb_adpll_ctrl;
  logic        REF_CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [9:0]  speed_req = '0;
  logic        speed_req_valid = 1'b0;
  logic        speed_req_ready;
  logic [9:0]  dco_code;
  logic [15:0] period_ps;
  logic        ADPLL_LOCK;
  logic        busy;
  logic        lock_lost;
  int checks = 0;
  int errors = 0;

  adpll_ctrl dut (
    .REF_CLK(REF_CLK), .RESET(RESET), .speed_req(speed_req),
    .speed_req_valid(speed_req_valid), .speed_req_ready(speed_req_ready),
    .dco_code(dco_code), .period_ps(period_ps), .ADPLL_LOCK(ADPLL_LOCK),
    .busy(busy), .lock_lost(lock_lost)
  );

  always #5 REF_CLK = ~REF_CLK;

  task automatic tick();
    @(posedge REF_CLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (dco_code !== 10'd0) begin errors++; $display("FAIL rst_dco got %0d want 0", dco_code); end
    checks++; if (period_ps !== 16'd900) begin errors++; $display("FAIL rst_period got %0d want 900", period_ps); end
    checks++; if (speed_req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_ready got ready=%b busy=%b want 1/0", speed_req_ready, busy); end
    tick();
    RESET = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (ADPLL_LOCK !== (i == 10)) begin errors++; $display("FAIL rst_lock edge %0d got %b want %b", i, ADPLL_LOCK, i == 10); end
    end
    checks++; if (dco_code !== 10'd0 || period_ps !== 16'd900) begin errors++; $display("FAIL rst_hold got %0d/%0d want 0/900", dco_code, period_ps); end
  endtask

  task automatic test_up();
    int seq [7] = '{16, 32, 48, 64, 80, 96, 100};
    speed_req = 10'd100; speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    checks++; if ({lock_lost, ADPLL_LOCK, busy} !== 3'b101 || dco_code !== 10'd0) begin errors++; $display("FAIL up_accept got ll=%b lk=%b busy=%b dco=%0d want 1/0/1/0", lock_lost, ADPLL_LOCK, busy, dco_code); end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (dco_code !== 10'(seq[i]) || busy !== (i != 6) || lock_lost !== 1'b0 || ADPLL_LOCK !== 1'b0) begin errors++; $display("FAIL up_ramp step %0d got dco=%0d busy=%b ll=%b lk=%b want %0d/%b/0/0", i, dco_code, busy, lock_lost, ADPLL_LOCK, seq[i], i != 6); end
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (ADPLL_LOCK !== (i == 10)) begin errors++; $display("FAIL up_relock edge %0d got %b want %b", i, ADPLL_LOCK, i == 10); end
    end
    checks++; if (period_ps !== 16'd1900) begin errors++; $display("FAIL up_period got %0d want 1900", period_ps); end
  endtask

  task automatic test_down();
    int seq [6] = '{84, 68, 52, 36, 20, 5};
    speed_req = 10'd5; speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    checks++; if (lock_lost !== 1'b1 || ADPLL_LOCK !== 1'b0) begin errors++; $display("FAIL down_accept got ll=%b lk=%b want 1/0", lock_lost, ADPLL_LOCK); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (dco_code !== 10'(seq[i]) || busy !== (i != 5)) begin errors++; $display("FAIL down_ramp step %0d got dco=%0d busy=%b want %0d/%b", i, dco_code, busy, seq[i], i != 5); end
    end
    checks++; if (period_ps !== 16'd950) begin errors++; $display("FAIL down_period got %0d want 950", period_ps); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (ADPLL_LOCK !== (i == 10)) begin errors++; $display("FAIL down_relock edge %0d got %b want %b", i, ADPLL_LOCK, i == 10); end
    end
  endtask

  task automatic test_handshake();
    speed_req = 10'd50; speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    tick();
    checks++; if (dco_code !== 10'd21) begin errors++; $display("FAIL hs_ramp1 got %0d want 21", dco_code); end
    speed_req = 10'd300; speed_req_valid = 1'b1;
    checks++; if (speed_req_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_low got %b want 0", speed_req_ready); end
    tick();
    checks++; if (dco_code !== 10'd37 || speed_req_ready !== 1'b0) begin errors++; $display("FAIL hs_ramp2 got dco=%0d rdy=%b want 37/0", dco_code, speed_req_ready); end
    tick();
    checks++; if (dco_code !== 10'd50 || busy !== 1'b0 || speed_req_ready !== 1'b1) begin errors++; $display("FAIL hs_ramp_end got dco=%0d busy=%b rdy=%b want 50/0/1", dco_code, busy, speed_req_ready); end
    tick();
    speed_req_valid = 1'b0;
    checks++; if (busy !== 1'b1 || lock_lost !== 1'b0 || dco_code !== 10'd50) begin errors++; $display("FAIL hs_accept got busy=%b ll=%b dco=%0d want 1/0/50", busy, lock_lost, dco_code); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++; if (dco_code !== 10'((50 + 16*k > 300) ? 300 : 50 + 16*k) || lock_lost !== 1'b0) begin errors++; $display("FAIL hs_ramp300 step %0d got dco=%0d ll=%b", k, dco_code, lock_lost); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_busy_end got %b want 0", busy); end
    for (int i = 1; i <= 10; i++) tick();
    checks++; if (ADPLL_LOCK !== 1'b1) begin errors++; $display("FAIL hs_lock300 got %b want 1", ADPLL_LOCK); end
    speed_req = 10'd300; speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    checks++; if ({ADPLL_LOCK, lock_lost, busy} !== 3'b100 || dco_code !== 10'd300) begin errors++; $display("FAIL hs_equal got lk=%b ll=%b busy=%b dco=%0d want 1/0/0/300", ADPLL_LOCK, lock_lost, busy, dco_code); end
    tick();
    checks++; if (ADPLL_LOCK !== 1'b1 || lock_lost !== 1'b0) begin errors++; $display("FAIL hs_equal_after got lk=%b ll=%b want 1/0", ADPLL_LOCK, lock_lost); end
  endtask

  task automatic test_async_reset();
    speed_req = 10'd600; speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    checks++; if (lock_lost !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ar_accept got ll=%b busy=%b want 1/1", lock_lost, busy); end
    tick();
    #1;
    RESET = 1'b0;
    #1;
    checks++; if (dco_code !== 10'd0 || ADPLL_LOCK !== 1'b0 || busy !== 1'b0 || lock_lost !== 1'b0) begin errors++; $display("FAIL ar_immediate got dco=%0d lk=%b busy=%b ll=%b want 0/0/0/0", dco_code, ADPLL_LOCK, busy, lock_lost); end
    checks++; if (period_ps !== 16'd900 || speed_req_ready !== 1'b1) begin errors++; $display("FAIL ar_period got %0d rdy=%b want 900/1", period_ps, speed_req_ready); end
    tick();
    RESET = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (ADPLL_LOCK !== (i == 10) || dco_code !== 10'd0) begin errors++; $display("FAIL ar_relock edge %0d got lk=%b dco=%0d want %b/0", i, ADPLL_LOCK, dco_code, i == 10); end
    end
  endtask

  task automatic test_range();
    speed_req = 10'd1023; speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      checks++; if (dco_code !== 10'((16*k > 1023) ? 1023 : 16*k) || busy !== (k != 64)) begin errors++; $display("FAIL range step %0d got dco=%0d busy=%b want %0d/%b", k, dco_code, busy, (16*k > 1023) ? 1023 : 16*k, k != 64); end
    end
    checks++; if (period_ps !== 16'd11130) begin errors++; $display("FAIL range_period got %0d want 11130", period_ps); end
    tick();
    checks++; if (dco_code !== 10'd1023) begin errors++; $display("FAIL range_hold got %0d want 1023", dco_code); end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_handshake();
    test_async_reset();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
